// File: rtl/jtdd_pkg.sv
// Shared definitions for the jtdd graphics ROM slots: fetch FSM encoding,
// SDRAM word width and the word base address of each graphics ROM region.
package jtdd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } fetch_state_t;

    localparam int SDRAM_DW = 16;

    localparam logic [21:0] CHAR_OFFSET = 22'h00_0000;
    localparam logic [21:0] SCR_OFFSET  = 22'h04_0000;
    localparam logic [21:0] OBJ_OFFSET  = 22'h08_0000;

    // Even byte lives in the low half of the SDRAM word.
    function automatic logic [7:0] byte_sel(input logic [SDRAM_DW-1:0] word, input logic odd);
        return odd ? word[15:8] : word[7:0];
    endfunction

endpackage

// File: rtl/jtdd_rom_cache2.sv
// Two-entry word cache: tag compare on both entries every cycle, single write
// port filling the entry under a round-robin replace pointer.
module jtdd_rom_cache2
    import jtdd_pkg::*;
#(
    parameter int TW = 14
)(
    input  logic                clk,
    input  logic                rst,
    input  logic [TW-1:0]       rd_tag,
    output logic                tag_hit,
    output logic [SDRAM_DW-1:0] rd_word,
    input  logic                wr_en,
    input  logic [TW-1:0]       wr_tag,
    input  logic [SDRAM_DW-1:0] wr_word
);

    logic [TW-1:0]       tag_reg  [2];
    logic [SDRAM_DW-1:0] data_reg [2];
    logic [1:0]          valid_reg;
    logic                ptr_reg;
    logic [1:0]          match;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_entry
            assign match[gi] = valid_reg[gi] && (tag_reg[gi] == rd_tag);

            // Payload needs no reset: the valid bit gates every use of it.
            always_ff @(posedge clk) begin
                if (wr_en && (ptr_reg == 1'(gi))) begin
                    tag_reg[gi]  <= wr_tag;
                    data_reg[gi] <= wr_word;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg <= 2'b00;
            ptr_reg   <= 1'b0;
        end else if (wr_en) begin
            valid_reg[ptr_reg] <= 1'b1;
            ptr_reg            <= ~ptr_reg;
        end
    end

    assign tag_hit = |match;
    // Entry 0 takes priority should both ever match.
    assign rd_word = match[0] ? data_reg[0] : data_reg[1];

endmodule

// File: rtl/jtdd_rom_slot.sv
// Graphics-layer ROM slot: serves byte reads from a two-word cache and fetches
// missing 16-bit words from the shared SDRAM controller.
module jtdd_rom_slot
    import jtdd_pkg::*;
#(
    parameter int              AW     = 15,
    parameter int              SDW    = 22,
    parameter logic [SDW-1:0]  OFFSET = '0
)(
    input  logic                clk,
    input  logic                rst,
    input  logic                slot_cs,
    input  logic [AW-1:0]       slot_addr,
    output logic [7:0]          slot_dout,
    output logic                slot_ok,
    output logic                sdram_req,
    output logic [SDW-1:0]      sdram_addr,
    input  logic                sdram_ack,
    input  logic                data_rdy,
    input  logic [SDRAM_DW-1:0] sdram_din
);

    localparam int TW = AW - 1;

    logic [TW-1:0]       word_idx;
    logic                tag_hit;
    logic                hit;
    logic                fill;
    logic [SDRAM_DW-1:0] hit_word;

    fetch_state_t        state_reg;
    logic                ok_reg;
    logic [AW-1:0]       addr_reg;
    logic [7:0]          dout_reg;
    logic                req_reg;
    logic [SDW-1:0]      sdaddr_reg;
    logic [TW-1:0]       fetch_tag_reg;

    assign word_idx = slot_addr[AW-1:1];
    assign hit      = slot_cs && tag_hit;
    // An ack carrying data in the same cycle completes the fetch straight from REQ.
    assign fill     = data_rdy && ((state_reg == ST_WAIT) ||
                                   (state_reg == ST_REQ && sdram_ack));

    jtdd_rom_cache2 #(
        .TW      (TW)
    ) u_cache (
        .clk     (clk),
        .rst     (rst),
        .rd_tag  (word_idx),
        .tag_hit (tag_hit),
        .rd_word (hit_word),
        .wr_en   (fill),
        .wr_tag  (fetch_tag_reg),
        .wr_word (sdram_din)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ok_reg   <= 1'b0;
            addr_reg <= '0;
            dout_reg <= '0;
        end else begin
            ok_reg   <= hit;
            addr_reg <= slot_addr;
            if (hit) begin
                dout_reg <= byte_sel(hit_word, slot_addr[0]);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            req_reg       <= 1'b0;
            sdaddr_reg    <= '0;
            fetch_tag_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (slot_cs && !tag_hit) begin
                        sdaddr_reg    <= OFFSET + {{(SDW-TW){1'b0}}, word_idx};
                        fetch_tag_reg <= word_idx;
                        req_reg       <= 1'b1;
                        state_reg     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (sdram_ack) begin
                        req_reg   <= 1'b0;
                        state_reg <= data_rdy ? ST_IDLE : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (data_rdy) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Guard drops ok in the very cycle the client moves to another address.
    assign slot_ok    = ok_reg && (slot_addr == addr_reg);
    assign slot_dout  = dout_reg;
    assign sdram_req  = req_reg;
    assign sdram_addr = sdaddr_reg;

endmodule
